// File: rtl/uart_word_assembler.sv
// Packs each group of four UART receive bytes into a 32-bit word behind a valid/ready output buffer.
// Optional inter-byte idle timeout is built only when WORD_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module uart_word_assembler #(
    parameter int unsigned MSB_FIRST      = 1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  RxData,
    input  logic        RxDone,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [1:0]  byte_idx,
    output logic        overrun,
    output logic        timeout
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t      state;
    logic [23:0] partial;
    logic [31:0] full_word;
    logic        accept;

    if (TIMEOUT_CYCLES < 32'd2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // partial holds earlier bytes in arrival order: {b0, b1, b2}
    assign full_word = (MSB_FIRST != 0) ? {partial, RxData}
                                        : {RxData, partial[7:0], partial[15:8], partial[23:16]};

    // Handshake: a word transfers on any edge where word_valid && word_ready; word_out holds
    // while word_valid && !word_ready, and a completed word may reload the buffer on the very
    // edge it is being consumed.
    assign accept = !word_valid || word_ready;

`ifdef WORD_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            partial    <= 24'd0;
            word_out   <= 32'd0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef WORD_TIMEOUT_EN
            idle_cnt   <= 32'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef WORD_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
`ifdef WORD_TIMEOUT_EN
                    idle_cnt <= 32'd0;
`endif
                    if (RxDone) begin
                        partial  <= {16'd0, RxData};
                        byte_idx <= 2'd1;
                        state    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (RxDone) begin
`ifdef WORD_TIMEOUT_EN
                        idle_cnt <= 32'd0;
`endif
                        if (byte_idx == 2'd3) begin
                            state    <= S_IDLE;
                            byte_idx <= 2'd0;
                            partial  <= 24'd0;
                            if (accept) begin
                                word_out   <= full_word;
                                word_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            partial  <= {partial[15:0], RxData};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
`ifdef WORD_TIMEOUT_EN
                    // A byte in the terminal-count cycle takes priority over the timeout.
                    else if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
                        state     <= S_IDLE;
                        byte_idx  <= 2'd0;
                        partial   <= 24'd0;
                        idle_cnt  <= 32'd0;
                        timeout_q <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: MSB-first and LSB-first instances share one stimulus
// stream; a negedge monitor pops expected words from per-instance queues on every transfer.
`timescale 1ns/1ps

module tb_uart_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        word_ready;

    logic [31:0] word_out_m, word_out_l;
    logic        word_valid_m, word_valid_l;
    logic [1:0]  byte_idx_m, byte_idx_l;
    logic        overrun_m, overrun_l;
    logic        timeout_m, timeout_l;

    logic [31:0] exp_msb_q[$];
    logic [31:0] exp_lsb_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_word_assembler #(.MSB_FIRST(1), .TIMEOUT_CYCLES(32'd100)) dut_msb (
        .Clk(clk), .Rst_n(rst_n), .RxData(rx_data), .RxDone(rx_done),
        .word_out(word_out_m), .word_valid(word_valid_m), .word_ready(word_ready),
        .byte_idx(byte_idx_m), .overrun(overrun_m), .timeout(timeout_m)
    );

    uart_word_assembler #(.MSB_FIRST(0), .TIMEOUT_CYCLES(32'd100)) dut_lsb (
        .Clk(clk), .Rst_n(rst_n), .RxData(rx_data), .RxDone(rx_done),
        .word_out(word_out_l), .word_valid(word_valid_l), .word_ready(word_ready),
        .byte_idx(byte_idx_l), .overrun(overrun_l), .timeout(timeout_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lsb_of(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic check_idx(input string tag, input logic [1:0] exp);
        check({tag, "_m"}, 32'(byte_idx_m), 32'(exp));
        check({tag, "_l"}, 32'(byte_idx_l), 32'(exp));
    endtask

    task automatic check_pair(input string tag, input logic obs_m, input logic obs_l, input logic exp);
        check({tag, "_m"}, 32'(obs_m), 32'(exp));
        check({tag, "_l"}, 32'(obs_l), 32'(exp));
    endtask

    // Sends w MSB byte first; 'accepted' says whether the buffer will take it.
    task automatic send_word(input logic [31:0] w, input bit accepted);
        logic [1:0] e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3 && accepted) begin
                exp_msb_q.push_back(w);
                exp_lsb_q.push_back(lsb_of(w));
            end
            send_byte(w[31-8*k -: 8]);
            e = 2'(k + 1);
            check_idx("byte_idx", e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && word_ready === 1'b1) begin
            if (word_valid_m === 1'b1) begin
                check("msb_q_nonempty", 32'(exp_msb_q.size() != 0), 32'd1);
                if (exp_msb_q.size() != 0) check("msb_word", word_out_m, exp_msb_q.pop_front());
            end
            if (word_valid_l === 1'b1) begin
                check("lsb_q_nonempty", 32'(exp_lsb_q.size() != 0), 32'd1);
                if (exp_lsb_q.size() != 0) check("lsb_word", word_out_l, exp_lsb_q.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  b1, b2, b3;
        bit          early;

        // reset
        rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_word_m", word_out_m, 32'd0);
        check("rst_word_l", word_out_l, 32'd0);
        check_pair("rst_valid", word_valid_m, word_valid_l, 1'b0);
        check_idx("rst_idx", 2'd0);
        check_pair("rst_overrun", overrun_m, overrun_l, 1'b0);
        check_pair("rst_timeout", timeout_m, timeout_l, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basic word, consumer always ready
        word_ready = 1'b1;
        send_word(32'h12345678, 1'b1);
        check_pair("basic_valid_hi", word_valid_m, word_valid_l, 1'b1);
        check("basic_word_m", word_out_m, 32'h12345678);
        check("basic_word_l", word_out_l, 32'h78563412);
        tick();
        check_pair("basic_valid_lo", word_valid_m, word_valid_l, 1'b0);

        // stalled consumer: second word overruns
        word_ready = 1'b0;
        send_word(32'hAABBCCDD, 1'b1);
        check_pair("stall_valid", word_valid_m, word_valid_l, 1'b1);
        check_pair("stall_no_ovr", overrun_m, overrun_l, 1'b0);
        send_word(32'h11223344, 1'b0);
        check_pair("ovr_pulse", overrun_m, overrun_l, 1'b1);
        check("ovr_word_m", word_out_m, 32'hAABBCCDD);
        check("ovr_word_l", word_out_l, 32'hDDCCBBAA);
        tick();
        check_pair("ovr_pulse_end", overrun_m, overrun_l, 1'b0);
        check_pair("ovr_still_valid", word_valid_m, word_valid_l, 1'b1);
        word_ready = 1'b1;
        tick();
        check_pair("drain_valid_lo", word_valid_m, word_valid_l, 1'b0);

        // consume and reload on the same edge
        word_ready = 1'b0;
        send_word(32'h01020304, 1'b1);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        check_idx("reload_idx3", 2'd3);
        word_ready = 1'b1;
        exp_msb_q.push_back(32'h05060708);
        exp_lsb_q.push_back(32'h08070605);
        send_byte(8'h08);
        check_pair("reload_no_ovr", overrun_m, overrun_l, 1'b0);
        check_pair("reload_valid", word_valid_m, word_valid_l, 1'b1);
        check("reload_word_m", word_out_m, 32'h05060708);
        check("reload_word_l", word_out_l, 32'h08070605);
        tick();
        check_pair("reload_drained", word_valid_m, word_valid_l, 1'b0);

`ifdef WORD_TIMEOUT_EN
        // idle timeout on a 2-byte partial word
        send_byte(8'h55);
        send_byte(8'h66);
        check_idx("to_idx2", 2'd2);
        early = 1'b0;
        repeat (99) begin
            tick();
            if (timeout_m !== 1'b0 || timeout_l !== 1'b0) early = 1'b1;
        end
        check("to_not_early", 32'(early), 32'd0);
        check_idx("to_idx_hold", 2'd2);
        tick();
        check_pair("to_pulse", timeout_m, timeout_l, 1'b1);
        check_idx("to_idx_clr", 2'd0);
        check_pair("to_buf_kept", word_valid_m, word_valid_l, 1'b0);
        tick();
        check_pair("to_pulse_end", timeout_m, timeout_l, 1'b0);
        send_word(32'hDEADBEEF, 1'b1);
        check("to_after_m", word_out_m, 32'hDEADBEEF);
        tick();

        // byte in the terminal-count cycle beats the timeout
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        b3 = 8'($urandom_range(0, 255));
        send_byte(8'h9A);
        early = 1'b0;
        repeat (99) begin
            tick();
            if (timeout_m !== 1'b0 || timeout_l !== 1'b0) early = 1'b1;
        end
        check("tc_not_early", 32'(early), 32'd0);
        send_byte(b1);
        check_pair("tc_no_timeout", timeout_m, timeout_l, 1'b0);
        check_idx("tc_idx2", 2'd2);
        tick();
        check_pair("tc_no_timeout2", timeout_m, timeout_l, 1'b0);
        exp_msb_q.push_back({8'h9A, b1, b2, b3});
        exp_lsb_q.push_back({b3, b2, b1, 8'h9A});
        send_byte(b2);
        send_byte(b3);
        check_pair("tc_valid", word_valid_m, word_valid_l, 1'b1);
        tick();
`else
        // without the timeout a partial word waits indefinitely
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        send_byte(8'h55);
        send_byte(8'h66);
        early = 1'b0;
        repeat (150) begin
            tick();
            if (timeout_m !== 1'b0 || timeout_l !== 1'b0) early = 1'b1;
        end
        check("nt_no_timeout", 32'(early), 32'd0);
        check_idx("nt_idx_hold", 2'd2);
        exp_msb_q.push_back({8'h55, 8'h66, b1, b2});
        exp_lsb_q.push_back({b2, b1, 8'h66, 8'h55});
        send_byte(b1);
        send_byte(b2);
        check_pair("nt_valid", word_valid_m, word_valid_l, 1'b1);
        tick();
`endif

        // reset mid-word with a word buffered
        word_ready = 1'b0;
        w = $urandom();
        send_word(w, 1'b1);
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        check_idx("mid_idx3", 2'd3);
        check_pair("mid_valid", word_valid_m, word_valid_l, 1'b1);
        #2;
        rst_n = 1'b0;
        rx_done = 1'b1;
        rx_data = 8'hFF;
        #1;
        check("mid_rst_word_m", word_out_m, 32'd0);
        check("mid_rst_word_l", word_out_l, 32'd0);
        check_pair("mid_rst_valid", word_valid_m, word_valid_l, 1'b0);
        check_idx("mid_rst_idx", 2'd0);
        exp_msb_q.delete();
        exp_lsb_q.delete();
        tick();
        tick();
        check_idx("rst_ignores_rxdone", 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_done = 1'b0;
        tick();
        check_idx("post_rst_idx", 2'd0);
        word_ready = 1'b1;
        send_word(32'hCAFEBABE, 1'b1);
        check("post_rst_word_m", word_out_m, 32'hCAFEBABE);
        check("post_rst_word_l", word_out_l, 32'hBEBAFECA);

        // back-to-back random words with the consumer always ready
        for (int i = 0; i < 4; i++) begin
            w = $urandom();
            send_word(w, 1'b1);
        end
        tick();
        tick();
        check_pair("end_valid", word_valid_m, word_valid_l, 1'b0);
        check("msb_q_drained", 32'(exp_msb_q.size()), 32'd0);
        check("lsb_q_drained", 32'(exp_lsb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
